// File: rtl/fft_axis_framer.sv
// Output stage of the pipelined FFT: turns the clock-enable/sync sample stream into a
// buffered valid/ready/last stream, flagging FIFO overflow and sync misalignment.
module fft_axis_framer #(
    parameter int WIDTH  = 24,
    parameter int LGSIZE = 5,
    parameter int LGFIFO = 4
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_ce,
    input  logic [2*WIDTH-1:0]   i_sample,
    input  logic                 i_sync,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [2*WIDTH-1:0]   o_data,
    output logic                 o_last,
    output logic                 o_overflow,
    output logic                 o_sync_err,
    output logic [LGFIFO:0]      o_fill
);

    localparam int D = 1 << LGFIFO;

    typedef enum logic [1:0] {HUNT, PASS, DROP} state_t;

    state_t              state;
    logic [LGSIZE-1:0]   index;
    logic [LGSIZE-1:0]   eff_index;
    logic [LGFIFO-1:0]   wr_ptr;
    logic [LGFIFO-1:0]   rd_ptr;
    logic [LGFIFO:0]     fill;
    logic [2*WIDTH:0]    mem [0:D-1];
    logic                pop;
    logic                writable;
    logic                push;
    logic                push_last;

    assign pop = (fill != '0) && i_ready;
    // fill never exceeds D, so its top bit alone means "full"
    assign writable = !fill[LGFIFO] || pop;

    // A sync always restarts the frame, so the sample is treated as index 0.
    assign eff_index = i_sync ? '0 : index;
    assign push      = i_ce && writable && ((state == PASS) || i_sync);
    assign push_last = &eff_index;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state      <= HUNT;
            index      <= '0;
            o_overflow <= 1'b0;
            o_sync_err <= 1'b0;
        end else begin
            o_overflow <= 1'b0;
            o_sync_err <= 1'b0;
            if (i_ce) begin
                unique case (state)
                    HUNT, DROP: begin
                        if (i_sync && writable) begin
                            state <= PASS;
                            index <= LGSIZE'(1);
                        end
                    end
                    PASS: begin
                        // Overflow wins over sync checking; the frame is abandoned.
                        if (!writable) begin
                            state      <= DROP;
                            o_overflow <= 1'b1;
                        end else begin
                            index      <= eff_index + 1'b1;
                            o_sync_err <= i_sync ? (index != '0) : (index == '0);
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: fill <= fill;
            endcase
        end
    end

    // Storage has no reset so it can map onto RAM; pointers alone define contents.
    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr] <= {push_last, i_sample};
    end

    assign o_valid           = (fill != '0);
    assign o_fill            = fill;
    assign {o_last, o_data}  = mem[rd_ptr];

endmodule
